// File: rtl/ddr2_refresh_scheduler.sv
// DDR2 auto-refresh scheduler: tREFI tick counting, pending-refresh accounting, PREA/REF command sequencing.
// Optional build macro DDR2_REF_BURST_EN: one grant drains every pending refresh back-to-back.
module ddr2_refresh_scheduler #(
  parameter int TREFI_CLK    = 1560,
  parameter int TRP_CLK      = 3,
  parameter int TRFC_CLK     = 26,
  parameter int MAX_POSTPONE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_en,
  input  logic       ref_gnt,
  output logic       ref_req,
  output logic       ref_urgent,
  output logic       ref_busy,
  output logic       ref_done,
  output logic       ref_overflow,
  output logic [3:0] pending_cnt,
  output logic       cmd_csbar,
  output logic       cmd_rasbar,
  output logic       cmd_casbar,
  output logic       cmd_webar,
  output logic       cmd_a10
);
  localparam int IW = $clog2(TREFI_CLK);
  localparam int TW = $clog2(TRP_CLK + TRFC_CLK + 1);
  localparam logic [IW-1:0] I_LAST   = IW'(TREFI_CLK - 1);
  localparam logic [TW-1:0] RP_LAST  = TW'((TRP_CLK  > 1) ? TRP_CLK  - 2 : 0);
  localparam logic [TW-1:0] RFC_LAST = TW'((TRFC_CLK > 1) ? TRFC_CLK - 2 : 0);
  // {csbar, rasbar, casbar, webar, a10}
  localparam logic [4:0] CMD_DESEL = 5'b11110;
  localparam logic [4:0] CMD_PREA  = 5'b00101;
  localparam logic [4:0] CMD_REF   = 5'b00010;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_PRE_ALL, S_WAIT_RP, S_REF, S_WAIT_RFC
  } state_t;

  state_t        r_state, w_next;
  logic [IW-1:0] r_icnt;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_pend, w_pend_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic          r_done, w_done, w_end;
  logic [4:0]    r_cmd, w_cmd;
  logic          w_tick, w_is_ref;

  assign w_tick   = refresh_en && (r_icnt == I_LAST);
  assign w_is_ref = (r_state == S_REF);

  // A tick landing in the REF cycle cancels that cycle's decrement.
  always_comb begin
    w_pend_nxt = r_pend;
    w_ovf_nxt  = r_ovf;
    if (!refresh_en) begin
      w_pend_nxt = 4'd0;
    end else if (w_tick && !w_is_ref) begin
      if (r_pend == 4'hF) w_ovf_nxt  = 1'b1;
      else                w_pend_nxt = r_pend + 4'd1;
    end else if (!w_tick && w_is_ref && r_pend != 4'd0) begin
      w_pend_nxt = r_pend - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_end  = 1'b0;
    w_done = 1'b0;
    w_cmd  = CMD_DESEL;
    case (r_state)
      S_IDLE:     if (r_pend != 4'd0) w_next = S_REQ;
      S_REQ: begin
        if (r_pend == 4'd0) w_next = S_IDLE;
        else if (ref_gnt)   w_next = S_PRE_ALL;
      end
      S_PRE_ALL:  w_next = (TRP_CLK > 1) ? S_WAIT_RP : S_REF;
      S_WAIT_RP:  if (r_tcnt == RP_LAST) w_next = S_REF;
      S_REF: begin
        if (TRFC_CLK > 1) w_next = S_WAIT_RFC;
        else              w_end  = 1'b1;
      end
      S_WAIT_RFC: if (r_tcnt == RFC_LAST) w_end = 1'b1;
      default:    w_next = S_IDLE;
    endcase
    if (w_end) begin
`ifdef DDR2_REF_BURST_EN
      w_next = (w_pend_nxt != 4'd0) ? S_REF : S_IDLE;
`else
      w_next = S_IDLE;
`endif
      w_done = (w_next == S_IDLE);
    end
    if (w_next == S_PRE_ALL)  w_cmd = CMD_PREA;
    else if (w_next == S_REF) w_cmd = CMD_REF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_icnt <= '0;
      r_tcnt <= '0;
      r_pend <= 4'd0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      r_cmd  <= CMD_DESEL;
    end else begin
      r_icnt <= (!refresh_en || w_tick) ? '0 : r_icnt + 1'b1;
      r_tcnt <= (w_next != r_state) ? '0 : r_tcnt + 1'b1;
      r_pend <= w_pend_nxt;
      r_ovf  <= w_ovf_nxt;
      r_done <= w_done;
      r_cmd  <= w_cmd;
    end
  end

  assign pending_cnt  = r_pend;
  assign ref_req      = (r_pend != 4'd0) && (r_state == S_REQ);
  assign ref_urgent   = (r_pend >= 4'(MAX_POSTPONE));
  assign ref_busy     = (r_state == S_PRE_ALL) || (r_state == S_WAIT_RP) ||
                        (r_state == S_REF)     || (r_state == S_WAIT_RFC);
  assign ref_done     = r_done;
  assign ref_overflow = r_ovf;
  assign {cmd_csbar, cmd_rasbar, cmd_casbar, cmd_webar, cmd_a10} = r_cmd;
endmodule

// File: tb/tb_ddr2_refresh_scheduler.sv
// Scoreboard bench for ddr2_refresh_scheduler (TREFI=100, TRP=3, TRFC=26); burst case under DDR2_REF_BURST_EN.
module tb_ddr2_refresh_scheduler;
  localparam int TREFI = 100;
  localparam int TRP   = 3;
  localparam int TRFC  = 26;
  localparam int EV_PRE = 0, EV_REF = 1, EV_DONE = 2, EV_BAD = 3;

  logic       clk = 1'b0, reset = 1'b1, refresh_en = 1'b1, ref_gnt = 1'b0;
  logic       ref_req, ref_urgent, ref_busy, ref_done, ref_overflow;
  logic [3:0] pending_cnt;
  logic       cmd_csbar, cmd_rasbar, cmd_casbar, cmd_webar, cmd_a10;

  ddr2_refresh_scheduler #(.TREFI_CLK(TREFI), .TRP_CLK(TRP), .TRFC_CLK(TRFC), .MAX_POSTPONE(8)) dut (
    .clk(clk), .reset(reset), .refresh_en(refresh_en), .ref_gnt(ref_gnt),
    .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_busy(ref_busy), .ref_done(ref_done),
    .ref_overflow(ref_overflow), .pending_cnt(pending_cnt),
    .cmd_csbar(cmd_csbar), .cmd_rasbar(cmd_rasbar), .cmd_casbar(cmd_casbar),
    .cmd_webar(cmd_webar), .cmd_a10(cmd_a10)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0, c0 = 0;

  typedef struct { int kind; int cyc; } ev_t;
  ev_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event @cyc %0d: got kind %0d expected none", cyc, kind);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: every command strobe and every ref_done must match the scoreboard head.
  always @(negedge clk) begin
    int k;
    if (cmd_csbar === 1'b0) begin
      k = EV_BAD;
      if ({cmd_rasbar, cmd_casbar, cmd_webar, cmd_a10} == 4'b0101) k = EV_PRE;
      else if ({cmd_rasbar, cmd_casbar, cmd_webar, cmd_a10} == 4'b0010) k = EV_REF;
      pop_cmp(k);
    end
    if (ref_done === 1'b1) pop_cmp(EV_DONE);
  end

  function automatic logic [31:0] outvec();
    return {18'd0, ref_req, ref_urgent, ref_busy, ref_done, ref_overflow, pending_cnt,
            cmd_csbar, cmd_rasbar, cmd_casbar, cmd_webar, cmd_a10};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ref_gnt = 1'b0; refresh_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_values", outvec(), 32'h0000_001E);
    reset = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_req(output int t);
    for (int i = 0; i < 300; i++) begin
      if (ref_req === 1'b1) begin t = cyc; return; end
      @(negedge clk);
    end
    t = -1;
    n_cmp++; n_err++;
    $display("FAIL ref_req_timeout @cyc %0d: got none expected ref_req", cyc);
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ref_done === 1'b1) return;
    end
    n_cmp++; n_err++;
    $display("FAIL ref_done_timeout @cyc %0d: got none expected ref_done", cyc);
  endtask

  // Grant seen in REQ: PREA next cycle, REF TRP later, ref_done TRFC after REF.
  task automatic grant(input bit full);
    ref_gnt = 1'b1;
    push(EV_PRE, cyc + 1);
    if (full) begin
      push(EV_REF,  cyc + 1 + TRP);
      push(EV_DONE, cyc + 1 + TRP + TRFC);
    end
    @(negedge clk);
    ref_gnt = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog @cyc %0d: got hang expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // 1: first request 101 cycles after release, single refresh sequence
    do_reset();
    wait_req(t);
    chk("t1_first_req_cycle", t, c0 + 101);
    grant(1'b1);
    wait_done(100);
    chk("t1_busy_at_done", ref_busy, 1'b0);
    chk("t1_pending_after", pending_cnt, 4'd0);

    // 2: eight postponed refreshes -> urgent
    do_reset();
    wait_until(c0 + 799);
    chk("t2_pend_7", pending_cnt, 4'd7);
    chk("t2_urgent_at_7", ref_urgent, 1'b0);
    @(negedge clk);
    chk("t2_pend_8", pending_cnt, 4'd8);
    chk("t2_urgent_at_8", ref_urgent, 1'b1);
`ifndef DDR2_REF_BURST_EN
    for (int k = 0; k < 8; k++) begin
      wait_req(t);
      grant(1'b1);
      if (k == 0) begin
        repeat (4) @(negedge clk);
        chk("t2_pend_after_first_ref", pending_cnt, 4'd7);
        chk("t2_urgent_drops", ref_urgent, 1'b0);
      end
      wait_done(100);
    end
    // ticks at +899 and +999 land during the drain
    chk("t2_pend_after_drain", pending_cnt, 4'd2);
`endif

    // 3: saturation and sticky overflow
    do_reset();
    wait_until(c0 + 1599);
    chk("t3_pend_15", pending_cnt, 4'd15);
    chk("t3_ovf_before", ref_overflow, 1'b0);
    chk("t3_urgent_15", ref_urgent, 1'b1);
    @(negedge clk);
    chk("t3_ovf_set", ref_overflow, 1'b1);
    chk("t3_pend_sat", pending_cnt, 4'd15);
    refresh_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_pend_cleared", pending_cnt, 4'd0);
    chk("t3_req_dropped", ref_req, 1'b0);
    chk("t3_ovf_sticky", ref_overflow, 1'b1);
    do_reset();
    chk("t3_ovf_cleared", ref_overflow, 1'b0);

`ifndef DDR2_REF_BURST_EN
    // 4: tick in the REF cycle (+199) with pending=1
    do_reset();
    wait_until(c0 + 195);
    grant(1'b1);
    wait_until(c0 + 200);
    chk("t4_pend_unchanged", pending_cnt, 4'd1);
    wait_done(100);
    @(negedge clk);
    chk("t4_rereq", ref_req, 1'b1);
`endif

    // 5: reset during WAIT_RP aborts the sequence
    do_reset();
    wait_req(t);
    grant(1'b0);
    @(negedge clk);
    chk("t5_busy_in_rp", ref_busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_abort_values", outvec(), 32'h0000_001E);
    reset = 1'b0;
    repeat (40) @(negedge clk);

`ifdef DDR2_REF_BURST_EN
    // 6: burst drains three pending refreshes on one grant
    do_reset();
    wait_until(c0 + 300);
    chk("t6_pend_3", pending_cnt, 4'd3);
    ref_gnt = 1'b1;
    push(EV_PRE,  cyc + 1);
    push(EV_REF,  cyc + 1 + TRP);
    push(EV_REF,  cyc + 1 + TRP + TRFC);
    push(EV_REF,  cyc + 1 + TRP + 2 * TRFC);
    push(EV_DONE, cyc + 1 + TRP + 3 * TRFC);
    @(negedge clk);
    ref_gnt = 1'b0;
    wait_done(200);
    chk("t6_pend_drained", pending_cnt, 4'd0);
`endif

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
